// File: rtl/buf_sched_pkg.sv
// Shared definitions for the port-A page-buffer burst scheduler: default widths,
// FSM state encoding, requester indices and a one-hot helper.
package buf_sched_pkg;

  localparam int BUF_ADDR_W = 11;
  localparam int BUF_DATA_W = 8;
  localparam int BUF_LEN_W  = BUF_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_NAND = 1'b1;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/buf_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
// The pointer only moves when the scheduler actually accepts a burst.
module buf_rr_arb
  import buf_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       winner
);

  logic last_gnt;

  always_comb begin
    winner = REQ_HOST;
    if (req == 2'b11) begin
      winner = ~last_gnt;
    end else if (req == 2'b10) begin
      winner = REQ_NAND;
    end
  end

  // Resetting to "NAND was last" makes the host win the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt <= REQ_NAND;
    end else if (accept) begin
      last_gnt <= winner;
    end
  end

endmodule

// File: rtl/buf_port_sched.sv
// Burst scheduler owning port A of the page buffer: arbitrates host/NAND bursts and
// runs one access per cycle. Optional macro BUF_SCHED_BOUND_EN rejects bursts past the end.
module buf_port_sched
  import buf_sched_pkg::*;
#(
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int DATA_W = BUF_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [1:0]          Req,
  input  logic [1:0]          ReqWr,
  input  logic [2*ADDR_W-1:0] ReqAddr,
  input  logic [2*LEN_W-1:0]  ReqLen,
  input  logic [2*DATA_W-1:0] WData,
  output logic [1:0]          Gnt,
  output logic [1:0]          DStrobe,
  output logic [1:0]          RValid,
  output logic [DATA_W-1:0]   RData,
  output logic [1:0]          Done,
  output logic [1:0]          Err,
  output logic                Busy,
  output logic [ADDR_W-1:0]   BufAddress,
  output logic [DATA_W-1:0]   BufDataIn,
  output logic                BufClockEn,
  output logic                BufWr,
  input  logic [DATA_W-1:0]   BufQ
);

  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  L_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  sched_state_t      state, state_n;
  logic              owner, owner_n;
  logic [ADDR_W-1:0] cur, cur_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [LEN_W-1:0]  remaining, rem_n;
  logic              ce_q, ce_n;
  logic              wr_q, wr_n;
  logic              rvalid_q;
  logic [1:0]        gnt_q, gnt_n;
  logic              accept;
  logic              winner;
  logic              reject;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;

  buf_rr_arb u_arb (
    .clock  (Clock),
    .reset  (Reset),
    .req    (Req),
    .accept (accept),
    .winner (winner)
  );

  assign sel_wr   = winner ? ReqWr[1] : ReqWr[0];
  assign sel_addr = winner ? ReqAddr[2*ADDR_W-1:ADDR_W] : ReqAddr[ADDR_W-1:0];
  assign sel_len  = winner ? ReqLen[2*LEN_W-1:LEN_W] : ReqLen[LEN_W-1:0];

`ifdef BUF_SCHED_BOUND_EN
  logic [LEN_W:0] span;
  logic [1:0]     err_q;

  assign span   = (LEN_W+1)'(sel_addr) + (LEN_W+1)'(sel_len);
  assign reject = span > (LEN_W+1)'(2**ADDR_W);

  // Err shares the Gnt timing: both register on the accepting IDLE cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      err_q <= 2'b00;
    end else if (accept && reject) begin
      err_q <= req_onehot(winner);
    end else begin
      err_q <= 2'b00;
    end
  end

  assign Err = err_q;
`else
  assign reject = 1'b0;
  assign Err    = 2'b00;
`endif

  // Next-state logic; the access signals for the coming cycle are computed here
  // so that BufAddress/BufWr/BufClockEn leave the block straight from flops.
  always_comb begin
    state_n = state;
    owner_n = owner;
    cur_n   = cur;
    rem_n   = remaining;
    addr_n  = addr_q;
    wr_n    = wr_q;
    ce_n    = 1'b0;
    gnt_n   = 2'b00;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|Req) begin
          accept  = 1'b1;
          owner_n = winner;
          gnt_n   = req_onehot(winner);
          if (reject || (sel_len == '0)) begin
            state_n = DRAIN;
            wr_n    = 1'b0;
          end else begin
            state_n = XFER;
            ce_n    = 1'b1;
            wr_n    = sel_wr;
            addr_n  = sel_addr;
            cur_n   = sel_addr + A_ONE;
            rem_n   = sel_len;
          end
        end
      end
      XFER: begin
        if (remaining == L_ONE) begin
          state_n = DRAIN;
          wr_n    = 1'b0;
          rem_n   = '0;
        end else begin
          ce_n   = 1'b1;
          addr_n = cur;
          cur_n  = cur + A_ONE;
          rem_n  = remaining - L_ONE;
        end
      end
      DRAIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // A reset anywhere abandons the burst; DRAIN is skipped, so no Done appears.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      owner     <= REQ_HOST;
      cur       <= '0;
      remaining <= '0;
      addr_q    <= '0;
      ce_q      <= 1'b0;
      wr_q      <= 1'b0;
      gnt_q     <= 2'b00;
      rvalid_q  <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      cur       <= cur_n;
      remaining <= rem_n;
      addr_q    <= addr_n;
      ce_q      <= ce_n;
      wr_q      <= wr_n;
      gnt_q     <= gnt_n;
      rvalid_q  <= ce_q & ~wr_q;
    end
  end

  assign Busy       = (state != IDLE);
  assign Gnt        = gnt_q;
  assign BufAddress = addr_q;
  assign BufClockEn = ce_q;
  assign BufWr      = wr_q;
  assign Done       = (state == DRAIN) ? req_onehot(owner) : 2'b00;
  assign DStrobe    = (ce_q & wr_q) ? req_onehot(owner) : 2'b00;
  assign RValid     = rvalid_q ? req_onehot(owner) : 2'b00;
  assign RData      = rvalid_q ? BufQ : '0;

  // The write byte goes straight from the owner's data bus to the buffer.
  assign BufDataIn = (ce_q & wr_q) ? (owner ? WData[2*DATA_W-1:DATA_W] : WData[DATA_W-1:0])
                                   : '0;

endmodule

// File: tb/tb_buf_port_sched.sv
// Directed bench for buf_port_sched: a cycle table for basic bursts plus hand-written
// sequences for wrap/bound, round-robin alternation, zero length and mid-burst reset.
module tb_buf_port_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_wr;
  logic [21:0] req_addr;
  logic [23:0] req_len;
  logic [15:0] wdata;
  logic [1:0]  gnt, dstrobe, rvalid, done, err;
  logic [7:0]  rdata;
  logic        busy;
  logic [10:0] buf_address;
  logic [7:0]  buf_data_in;
  logic        buf_clock_en;
  logic        buf_wr;
  logic [7:0]  buf_q;

  logic [7:0]  mem [0:2047];

  int vectors_applied = 0;
  int miscompares     = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  req_wr;
    logic [10:0] addr0;
    logic [11:0] len0;
    logic [10:0] addr1;
    logic [11:0] len1;
    logic [7:0]  wd0;
    logic [1:0]  gnt;
    logic [1:0]  dstrobe;
    logic [1:0]  rvalid;
    logic [1:0]  done;
    logic        busy;
    logic        ce;
    logic        wr;
    logic [10:0] address;
    logic [7:0]  din;
    logic [7:0]  rdata;
  } vec_t;

  vec_t table_q[$];

  buf_port_sched dut (
    .Clock      (clock),
    .Reset      (reset),
    .Req        (req),
    .ReqWr      (req_wr),
    .ReqAddr    (req_addr),
    .ReqLen     (req_len),
    .WData      (wdata),
    .Gnt        (gnt),
    .DStrobe    (dstrobe),
    .RValid     (rvalid),
    .RData      (rdata),
    .Done       (done),
    .Err        (err),
    .Busy       (busy),
    .BufAddress (buf_address),
    .BufDataIn  (buf_data_in),
    .BufClockEn (buf_clock_en),
    .BufWr      (buf_wr),
    .BufQ       (buf_q)
  );

  always #5 clock = ~clock;

  // Page-buffer port A model: synchronous write, registered read.
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h7FC] = 8'h55;
    mem[11'h7FD] = 8'h66;
    mem[11'h7FE] = 8'h11;
    mem[11'h7FF] = 8'h22;
    mem[11'h000] = 8'h33;
    mem[11'h001] = 8'h44;
    buf_q = 8'h00;
  end

  always @(posedge clock) begin
    if (buf_clock_en) begin
      if (buf_wr) mem[buf_address] <= buf_data_in;
      else        buf_q <= mem[buf_address];
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_ctl(input string name, input logic [1:0] e_gnt, input logic [1:0] e_ds,
                           input logic [1:0] e_rv, input logic [1:0] e_done,
                           input logic [1:0] e_err, input logic e_busy, input logic e_ce,
                           input logic e_wr);
    check_output(name, {gnt, dstrobe, rvalid, done, err, busy, buf_clock_en, buf_wr},
                 {e_gnt, e_ds, e_rv, e_done, e_err, e_busy, e_ce, e_wr});
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [1:0] r, input logic [1:0] w, input logic [10:0] a0,
                         input logic [11:0] l0, input logic [10:0] a1, input logic [11:0] l1);
    req      = r;
    req_wr   = w;
    req_addr = {a1, a0};
    req_len  = {l1, l0};
  endtask

  task automatic add_row(input logic [1:0] r, input logic [1:0] w, input logic [10:0] a0,
                         input logic [11:0] l0, input logic [10:0] a1, input logic [11:0] l1,
                         input logic [7:0] wd, input logic [1:0] e_gnt, input logic [1:0] e_ds,
                         input logic [1:0] e_rv, input logic [1:0] e_done, input logic e_busy,
                         input logic e_ce, input logic e_wr, input logic [10:0] e_addr,
                         input logic [7:0] e_din, input logic [7:0] e_rdata);
    vec_t v;
    v.req = r; v.req_wr = w; v.addr0 = a0; v.len0 = l0; v.addr1 = a1; v.len1 = l1; v.wd0 = wd;
    v.gnt = e_gnt; v.dstrobe = e_ds; v.rvalid = e_rv; v.done = e_done; v.busy = e_busy;
    v.ce = e_ce; v.wr = e_wr; v.address = e_addr; v.din = e_din; v.rdata = e_rdata;
    table_q.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    set_req(v.req, v.req_wr, v.addr0, v.len0, v.addr1, v.len1);
    wdata = {8'h00, v.wd0};
  endtask

  initial begin
    logic [10:0] a;
    logic [7:0]  wrap_data [4];
    logic [1:0]  e_gnt, e_rv, e_done;
    logic        e_ce;
    vec_t        v;

    wrap_data[0] = 8'h11; wrap_data[1] = 8'h22; wrap_data[2] = 8'h33; wrap_data[3] = 8'h44;

    //       req    wr     a0      l0     a1      l1     wd     gnt    ds     rv     done   by ce wr addr    din    rdata
    // host write 0x010, len 4, A0..A3
    add_row(2'b01, 2'b01, 11'h010, 12'd4, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 11'h000, 8'h00, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'hA0, 2'b01, 2'b01, 2'b00, 2'b00, 1, 1, 1, 11'h010, 8'hA0, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'hA1, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 1, 11'h011, 8'hA1, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'hA2, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 1, 11'h012, 8'hA2, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'hA3, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 1, 11'h013, 8'hA3, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0, 11'h000, 8'h00, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 11'h000, 8'h00, 8'h00);
    // host read back 0x010, len 4
    add_row(2'b01, 2'b00, 11'h010, 12'd4, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 11'h000, 8'h00, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0, 11'h010, 8'h00, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1, 0, 11'h011, 8'h00, 8'hA0);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1, 0, 11'h012, 8'h00, 8'hA1);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1, 0, 11'h013, 8'h00, 8'hA2);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0, 0, 11'h000, 8'h00, 8'hA3);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 11'h000, 8'h00, 8'h00);
    // NAND read 0x7FC, len 2
    add_row(2'b10, 2'b00, 11'h000, 12'd0, 11'h7FC, 12'd2, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 11'h000, 8'h00, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1, 0, 11'h7FC, 8'h00, 8'h00);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b10, 2'b00, 1, 1, 0, 11'h7FD, 8'h00, 8'h55);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b10, 2'b10, 1, 0, 0, 11'h000, 8'h00, 8'h66);
    add_row(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 11'h000, 8'h00, 8'h00);

    reset = 1'b1;
    set_req(2'b00, 2'b00, 11'h000, 12'd0, 11'h000, 12'd0);
    wdata = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    check_output("reset_state",
                 {gnt, dstrobe, rvalid, done, err, busy, buf_address, buf_clock_en, buf_wr,
                  buf_data_in, rdata}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < table_q.size(); i++) begin
      v = table_q[i];
      apply_stimulus(v);
      #1;
      check_ctl($sformatf("row%0d_ctl", i), v.gnt, v.dstrobe, v.rvalid, v.done, 2'b00,
                v.busy, v.ce, v.wr);
      if (v.ce) check_output($sformatf("row%0d_addr", i), buf_address, v.address);
      if (v.dstrobe != 2'b00) check_output($sformatf("row%0d_din", i), buf_data_in, v.din);
      if (v.rvalid != 2'b00) check_output($sformatf("row%0d_rdata", i), rdata, v.rdata);
      next_cycle();
    end

    // NAND read starting at 0x7FE, length 4: wraps past the top of the buffer
    set_req(2'b10, 2'b00, 11'h000, 12'd0, 11'h7FE, 12'd4);
    #1;
`ifdef BUF_SCHED_BOUND_EN
    next_cycle();
    req = 2'b00;
    #1;
    check_ctl("wrap_reject", 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0);
    next_cycle();
    check_ctl("wrap_reject_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
`else
    a = 11'h7FE;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 1) req = 2'b00;
      #1;
      e_ce   = (c <= 4);
      e_gnt  = (c == 1) ? 2'b10 : 2'b00;
      e_rv   = (c >= 2 && c <= 5) ? 2'b10 : 2'b00;
      e_done = (c == 5) ? 2'b10 : 2'b00;
      check_ctl($sformatf("wrap_c%0d", c), e_gnt, 2'b00, e_rv, e_done, 2'b00, (c <= 5),
                e_ce, 1'b0);
      if (e_ce) begin
        check_output($sformatf("wrap_addr_c%0d", c), buf_address, a);
        a = a + 11'd1;
      end
      if (e_rv != 2'b00) check_output($sformatf("wrap_rdata_c%0d", c), rdata, wrap_data[c-2]);
    end
`endif

    // Both requesters held: grants alternate host, NAND, host, NAND, 4 cycles apart
    set_req(2'b11, 2'b00, 11'h010, 12'd2, 11'h7FC, 12'd2);
    #1;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      if (c == 14) req = 2'b00;
      #1;
      e_gnt = ((c % 4) == 1) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check_output($sformatf("rr_gnt_c%0d", c), gnt, e_gnt);
      check_output($sformatf("rr_busy_c%0d", c), busy, ((c % 4) != 0));
    end

    // Zero-length burst on NAND: Gnt and Done together, no buffer access
    set_req(2'b10, 2'b00, 11'h000, 12'd0, 11'h020, 12'd0);
    #1;
    next_cycle();
    req = 2'b00;
    #1;
    check_ctl("len0_drain", 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
    next_cycle();
    check_ctl("len0_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Host read 0x7FC, length 8: rejected with the bound check, else wraps to 0x003
    set_req(2'b01, 2'b00, 11'h7FC, 12'd8, 11'h000, 12'd0);
    #1;
`ifdef BUF_SCHED_BOUND_EN
    next_cycle();
    req = 2'b00;
    #1;
    check_ctl("bound_reject", 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    next_cycle();
    check_ctl("bound_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
`else
    a = 11'h7FC;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 1) req = 2'b00;
      #1;
      e_ce   = (c <= 8);
      e_gnt  = (c == 1) ? 2'b01 : 2'b00;
      e_rv   = (c >= 2 && c <= 9) ? 2'b01 : 2'b00;
      e_done = (c == 9) ? 2'b01 : 2'b00;
      check_ctl($sformatf("bound_c%0d", c), e_gnt, 2'b00, e_rv, e_done, 2'b00, (c <= 9),
                e_ce, 1'b0);
      if (e_ce) begin
        check_output($sformatf("bound_addr_c%0d", c), buf_address, a);
        a = a + 11'd1;
      end
    end
`endif

    // Reset during the 3rd beat of a 16-byte host write
    set_req(2'b01, 2'b01, 11'h100, 12'd16, 11'h000, 12'd0);
    wdata = 16'h005A;
    #1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 1) req = 2'b00;
      #1;
      check_output($sformatf("rst_beat%0d_addr", c), {buf_clock_en, buf_address},
                   {1'b1, 11'h100 + 11'(c - 1)});
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    check_output("rst_all_zero",
                 {gnt, dstrobe, rvalid, done, err, busy, buf_address, buf_clock_en, buf_wr,
                  buf_data_in, rdata}, 64'd0);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      check_ctl($sformatf("rst_quiet_c%0d", c), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0,
                1'b0, 1'b0);
    end

    // After reset the pointer favours the host again on a tie
    set_req(2'b11, 2'b00, 11'h010, 12'd1, 11'h7FC, 12'd1);
    wdata = 16'h0000;
    #1;
    next_cycle();
    req = 2'b00;
    #1;
    check_ctl("post_rst_gnt", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    check_output("post_rst_addr", buf_address, 11'h010);
    next_cycle();
    check_ctl("post_rst_done", 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    check_output("post_rst_rdata", rdata, 8'hA0);
    next_cycle();
    check_ctl("post_rst_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/buf_port_sched.md
# buf_port_sched

Two-requester burst scheduler that owns port A of the 2048×8 dual-port page buffer. It arbitrates round-robin between the host interface (requester 0) and the NAND data engine (requester 1). It then sequences the granted burst as one buffer access per cycle and routes read data back to the owner. Port B stays dedicated to the ECC path and is outside this block.

## Interface
- ADDR_W, 11, buffer address width (2048 entries)
- DATA_W, 8, byte width
- LEN_W, ADDR_W+1, burst length width (0..2048)
- Clock  in  1  single clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- Req  in  2  bit i = requester i wants a burst; held until its Gnt
- ReqWr  in  2  bit i = 1 write to buffer, 0 read
- ReqAddr  in  2×ADDR_W  packed, slice i = start address
- ReqLen  in  2×LEN_W  packed, slice i = byte count
- WData  in  2×DATA_W  packed, slice i = write byte, valid whenever DStrobe[i] is high
- Gnt  out  2  one-cycle pulse, burst accepted
- DStrobe  out  2  write byte consumed this cycle; requester advances next cycle
- RValid  out  2  RData valid for requester i
- RData  out  DATA_W  read byte, shared
- Done  out  2  one-cycle pulse, burst complete
- Err  out  2  one-cycle pulse, burst rejected (only with BUF_SCHED_BOUND_EN)
- Busy  out  1  state ≠ IDLE
- BufAddress  out  ADDR_W  to AddressA
- BufDataIn  out  DATA_W  to DataInA
- BufClockEn  out  1  to ClockEnA
- BufWr  out  1  to WrA
- BufQ  in  DATA_W  from QA

## Operation
- FSM states: IDLE, XFER, DRAIN.
- IDLE: if any Req is set, the arbiter picks a winner. Priority goes to the requester not granted last; the pointer resets so requester 0 wins the first tie. The block latches wr, addr and len.
  - len ≠ 0: go to XFER.
  - len = 0: go to DRAIN with no buffer access.
- XFER: each cycle drives BufClockEn=1, BufAddress=cur, BufWr=wr.
  - Writes: DStrobe[owner]=1 and BufDataIn=WData[owner]. The BufDataIn mux is combinational.
  - cur increments mod 2048 (2047→0); remaining decrements.
  - When remaining reaches 1 the block goes to DRAIN.
  - The requester cannot stall; a granted burst always runs at 1 byte/cycle.
- DRAIN: one cycle. Done[owner] pulses, then the block returns to IDLE.
- Gnt[owner] pulses in the first cycle after leaving IDLE: the first XFER cycle, or DRAIN when len=0 or the burst is rejected.
- Read return: RValid[owner] is a registered copy of (BufClockEn & ~BufWr), so it is high the cycle after each read access. RData = BufQ.
- Req still high in IDLE after Done starts a new burst; it does not wait for Req to fall.
- Reset mid-burst: the burst is abandoned. No Done, and the state goes to IDLE.
- Reset values: all outputs 0, state IDLE, cur and remaining 0, round-robin pointer favouring requester 0.

## Timing
- Request seen in IDLE at cycle t → Gnt and first access at t+1.
- Access k (k=0..L-1) happens at cycle t+1+k. The read byte k appears at t+2+k.
- Done and the last RValid both fall in cycle t+1+L. IDLE is at t+2+L.
- A burst of L bytes occupies L+2 cycles, IDLE cycle included.
- BufAddress, BufWr and BufClockEn are registered. Only BufDataIn is combinational.

## Configuration
- BUF_SCHED_BOUND_EN defined: in IDLE, addr+len > 2048 causes a reject.
  - The block goes to DRAIN with Gnt, Err and Done pulsing together in the same cycle.
  - No buffer access occurs.
- Undefined: addresses wrap modulo 2048. The Err port exists and is tied 0.

## Structure
- Package buf_sched_pkg holds:
  - ADDR_W, DATA_W and LEN_W defaults
  - state enum {IDLE, XFER, DRAIN}
  - requester indices REQ_HOST=0 and REQ_NAND=1
- Sub-module buf_rr_arb: the 2-way round-robin arbiter, with last-grant pointer update on each accept.

## Test plan
- Host write, addr 0x010, len 4, bytes A0..A3 → Gnt[0] at t+1, DStrobe[0] for 4 cycles, addresses 0x010..0x013, Done[0] at t+5. Later read back gives A0..A3.
- NAND read, addr 0x7FE, len 4 (macro off) → addresses 0x7FE, 0x7FF, 0x000, 0x001; RValid[1] for 4 cycles; Done coincides with the last RValid.
- Req=2'b11 held continuously, both len 2 → grants alternate 0,1,0,1. Each burst takes 4 cycles.
- len=0 on requester 1 → Gnt[1] and Done[1] in the same cycle, BufClockEn never high.
- BUF_SCHED_BOUND_EN set, addr 0x7FC, len 8 → Gnt, Err and Done pulse together, no access. The same stimulus with the macro off wraps to 0x003.
- Reset asserted during the 3rd beat of a len-16 write → the next cycle has all outputs 0, no Done, Busy=0. A new request is then granted normally.
